// File: rtl/encode_pipe_slice_pkg.sv
`timescale 1ns/1ps
// Shared helpers for the tkeep encoder: log2, popcount, keep encoding and
// packet-tracker states. Decoders elsewhere import the same package.
package encode_pipe_slice_pkg;

  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_IN   = 1'b1
  } pkt_state_e;

  localparam int KEEP_MAX_W = 64;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [6:0] popcount(input logic [KEEP_MAX_W-1:0] keep);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) n = n + 7'(keep[i]);
    return n;
  endfunction

  // Index of the highest set bit: equals popcount-1 for contiguous LSB-aligned
  // keep, and gives the forwarded value for illegal patterns (0 for all-zero).
  function automatic logic [5:0] keep_encode(input logic [KEEP_MAX_W-1:0] keep);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (keep[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  function automatic logic keep_legal(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/encode_pipe_slice_if.sv
`timescale 1ns/1ps
// AXI-Stream bus with tuser sideband; tkeep on the way in, tkeep_enc on the way out.
interface encode_pipe_slice_if #(
  parameter int DATA_W    = 256,
  parameter int PLEN_W    = 14,
  parameter int INPORT_W  = 3,
  parameter int OUTPORT_W = 8
) ();
  import encode_pipe_slice_pkg::*;

  localparam int KEEP_W = DATA_W / 8;
  localparam int ENC_W  = log2(KEEP_W);

  logic [DATA_W-1:0]    tdata;
  logic [KEEP_W-1:0]    tkeep;
  logic [ENC_W-1:0]     tkeep_enc;
  logic [PLEN_W-1:0]    tuser_packet_length;
  logic [INPORT_W-1:0]  tuser_in_port;
  logic [OUTPORT_W-1:0] tuser_out_port;
  logic [INPORT_W-1:0]  tuser_in_vport;
  logic [OUTPORT_W-1:0] tuser_out_vport;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;

  modport master (
    output tdata, tkeep, tkeep_enc, tuser_packet_length, tuser_in_port,
           tuser_out_port, tuser_in_vport, tuser_out_vport, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tkeep_enc, tuser_packet_length, tuser_in_port,
           tuser_out_port, tuser_in_vport, tuser_out_vport, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/encode_skid_stage.sv
`timescale 1ns/1ps
// Two-entry skid register slice: full throughput, in_ready comes straight from a flop.
module encode_skid_stage #(
  parameter int W = 8
) (
  input  logic         axi_aclk,
  input  logic         axi_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_reg, main_valid_next;
  logic         skid_valid_reg, skid_valid_next;
  logic         ready_reg;
  logic [W-1:0] main_data_reg, main_data_next;
  logic [W-1:0] skid_data_reg, skid_data_next;
  logic         in_fire, out_fire;

  assign in_fire   = in_valid & ready_reg;
  assign out_fire  = main_valid_reg & out_ready;
  assign in_ready  = ready_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

  // Input is only accepted while skid is empty, so skid always drains first.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (!main_valid_reg || out_fire) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end else begin
        main_valid_next = in_fire;
        main_data_next  = in_data;
      end
    end else if (in_fire) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= !skid_valid_next;
    end
  end

  always_ff @(posedge axi_aclk) begin
    main_data_reg <= main_data_next;
    skid_data_reg <= skid_data_next;
  end

endmodule

// File: rtl/encode_pipe_slice.sv
`timescale 1ns/1ps
// tkeep encoder behind C_STAGES skid slices, with sticky keep error and,
// when ENCODE_PIPE_LEN_CHECK_EN is defined, a per-packet length checker.
module encode_pipe_slice #(
  parameter int C_AXIS_DATA_WIDTH     = 256,
  parameter int C_PACKET_LENGTH_WIDTH = 14,
  parameter int C_INPORT_WIDTH        = 3,
  parameter int C_OUTPORT_WIDTH       = 8,
  parameter int C_STAGES              = 1
) (
  input  logic                axi_aclk,
  input  logic                axi_resetn,
  encode_pipe_slice_if.slave  s_axis,
  encode_pipe_slice_if.master m_axis,
  output logic                keep_err,
  output logic [15:0]         len_err_cnt
);
  import encode_pipe_slice_pkg::*;

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
  localparam int ENC_W  = log2(KEEP_W);
  localparam int PAY_W  = C_AXIS_DATA_WIDTH + KEEP_W + ENC_W + C_PACKET_LENGTH_WIDTH
                        + 2 * C_INPORT_WIDTH + 2 * C_OUTPORT_WIDTH + 1;

  logic [KEEP_MAX_W-1:0] keep_ext;
  logic [ENC_W-1:0]      enc_in;
  logic                  keep_ok;
  logic                  s_fire;
  logic                  keep_err_reg;
  logic                  unused_s_enc;

  assign keep_ext     = KEEP_MAX_W'(s_axis.tkeep);
  assign enc_in       = ENC_W'(keep_encode(keep_ext));
  assign keep_ok      = keep_legal(keep_ext);
  assign s_fire       = s_axis.tvalid & s_axis.tready;
  assign unused_s_enc = ^s_axis.tkeep_enc;

  logic [PAY_W-1:0] stage_data  [C_STAGES+1];
  logic             stage_valid [C_STAGES+1];
  logic             stage_ready [C_STAGES+1];

  assign stage_data[0]  = {s_axis.tdata, s_axis.tkeep, enc_in, s_axis.tuser_packet_length,
                           s_axis.tuser_in_port, s_axis.tuser_out_port,
                           s_axis.tuser_in_vport, s_axis.tuser_out_vport, s_axis.tlast};
  assign stage_valid[0] = s_axis.tvalid;
  assign s_axis.tready  = stage_ready[0];
  assign stage_ready[C_STAGES] = m_axis.tready;

  generate
    for (genvar gi = 0; gi < C_STAGES; gi++) begin : g_stage
      encode_skid_stage #(.W(PAY_W)) u_stage (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .in_valid   (stage_valid[gi]),
        .in_ready   (stage_ready[gi]),
        .in_data    (stage_data[gi]),
        .out_valid  (stage_valid[gi+1]),
        .out_ready  (stage_ready[gi+1]),
        .out_data   (stage_data[gi+1])
      );
    end
  endgenerate

  assign m_axis.tvalid = stage_valid[C_STAGES];
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tkeep_enc, m_axis.tuser_packet_length,
          m_axis.tuser_in_port, m_axis.tuser_out_port,
          m_axis.tuser_in_vport, m_axis.tuser_out_vport, m_axis.tlast} = stage_data[C_STAGES];

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn)           keep_err_reg <= 1'b0;
    else if (s_fire && !keep_ok) keep_err_reg <= 1'b1;
  end
  assign keep_err = keep_err_reg;

`ifdef ENCODE_PIPE_LEN_CHECK_EN
  localparam int SUM_W = C_PACKET_LENGTH_WIDTH + 1;

  pkt_state_e                     state_reg, state_next;
  logic                           first_beat;
  logic [SUM_W-1:0]               sum_reg, beat_sum;
  logic [C_PACKET_LENGTH_WIDTH-1:0] len_reg, len_cur;
  logic [15:0]                    len_err_cnt_reg;

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) state_reg <= PKT_IDLE;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (s_fire) state_next = s_axis.tlast ? PKT_IDLE : PKT_IN;
  end

  always_comb begin
    first_beat = (state_reg == PKT_IDLE);
  end

  // A single-beat packet is both first and last: its own length and bytes are compared.
  always_comb begin
    beat_sum = (first_beat ? '0 : sum_reg) + SUM_W'(popcount(keep_ext));
    len_cur  = first_beat ? s_axis.tuser_packet_length : len_reg;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      sum_reg         <= '0;
      len_reg         <= '0;
      len_err_cnt_reg <= '0;
    end else if (s_fire) begin
      sum_reg <= beat_sum;
      if (first_beat) len_reg <= s_axis.tuser_packet_length;
      if (s_axis.tlast && (beat_sum != {1'b0, len_cur}) && (len_err_cnt_reg != 16'hFFFF))
        len_err_cnt_reg <= len_err_cnt_reg + 16'd1;
    end
  end
  assign len_err_cnt = len_err_cnt_reg;
`else
  assign len_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_encode_pipe_slice.sv
`timescale 1ns/1ps
// Directed bench for encode_pipe_slice with C_STAGES=2 and a queue scoreboard.
module tb_encode_pipe_slice;

`ifdef ENCODE_PIPE_LEN_CHECK_EN
  localparam int LC = 1;
`else
  localparam int LC = 0;
`endif

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [4:0]   enc;
    logic [13:0]  plen;
    logic [2:0]   inp;
    logic [7:0]   outp;
    logic [2:0]   inv;
    logic [7:0]   outv;
    logic         last;
    int           cyc;
  } beat_t;

  typedef struct {
    logic [31:0] keep;
    logic [4:0]  enc;
    logic        bad;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        keep_err;
  logic [15:0] len_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;
  int n_beats  = 0;
  logic [4:0] exp_enc;
  bit   stamp_en = 0;
  bit   prev_stall = 0;
  logic [329:0] prev_word;
  logic [4:0] last_enc;
  logic [2:0] last_inv;
  logic [7:0] last_outv;

  beat_t exp_q[$];
  int    lat_q[$];
  int    ocyc_q[$];
  vec_t  tbl[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  encode_pipe_slice_if #(.DATA_W(256), .PLEN_W(14), .INPORT_W(3), .OUTPORT_W(8)) s_if ();
  encode_pipe_slice_if #(.DATA_W(256), .PLEN_W(14), .INPORT_W(3), .OUTPORT_W(8)) m_if ();

  encode_pipe_slice #(
    .C_AXIS_DATA_WIDTH     (256),
    .C_PACKET_LENGTH_WIDTH (14),
    .C_INPORT_WIDTH        (3),
    .C_OUTPORT_WIDTH       (8),
    .C_STAGES              (2)
  ) dut (
    .axi_aclk    (clk),
    .axi_resetn  (resetn),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .keep_err    (keep_err),
    .len_err_cnt (len_err_cnt)
  );

  function automatic logic [329:0] pack(input beat_t b);
    return {b.data, b.keep, b.enc, b.plen, b.inp, b.outp, b.inv, b.outv, b.last};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] keep, input logic [4:0] enc, input logic last,
                      input logic [2:0] inv, input logic [7:0] outv, input logic [13:0] plen);
    bit acc;
    int k;
    s_if.tdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s_if.tkeep = keep;
    exp_enc = enc;
    s_if.tuser_packet_length = plen;
    s_if.tuser_in_port  = 3'($urandom);
    s_if.tuser_out_port = 8'($urandom);
    s_if.tuser_in_vport  = inv;
    s_if.tuser_out_vport = outv;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    acc = 0;
    k = 0;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      k++;
    end
    s_if.tvalid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got tready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      cycles(1);
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output ready: 0 = always ready, 1 = random with a comb-path probe, 2 = stalled.
  always @(posedge clk) begin : ready_drv
    logic rb;
    #1;
    case (mode)
      1: begin
        rb = s_if.tready;
        m_if.tready = 1'($urandom_range(0, 1));
        #1;
        check("s_tready_comb", 32'(s_if.tready), 32'(rb));
      end
      2: m_if.tready = 1'b0;
      default: m_if.tready = 1'b1;
    endcase
  end

  always @(negedge clk) begin : monitor
    beat_t a, e;
    logic [329:0] w;
    a.data = m_if.tdata; a.keep = m_if.tkeep; a.enc = m_if.tkeep_enc;
    a.plen = m_if.tuser_packet_length; a.inp = m_if.tuser_in_port;
    a.outp = m_if.tuser_out_port; a.inv = m_if.tuser_in_vport;
    a.outv = m_if.tuser_out_vport; a.last = m_if.tlast; a.cyc = cyc;
    w = pack(a);
    if (!resetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!m_if.tvalid || w !== prev_word) begin
          n_fail++;
          $display("FAIL m_stable: got valid=%0d %0h expected valid=1 %0h", m_if.tvalid, w, prev_word);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", w);
        end else begin
          e = exp_q.pop_front();
          if (w !== pack(e)) begin
            n_fail++;
            $display("FAIL beat_fields: got %0h expected %0h", w, pack(e));
          end else begin
            n_beats++;
            $display("beat %0d enc=%0d last=%0d vport=%0h/%0h ok", n_beats, a.enc, a.last, a.inv, a.outv);
          end
          if (stamp_en) begin
            lat_q.push_back(cyc - e.cyc);
            ocyc_q.push_back(cyc);
          end
        end
        last_enc = a.enc; last_inv = a.inv; last_outv = a.outv;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_word = w;
      if (s_if.tvalid && s_if.tready) begin
        e.data = s_if.tdata; e.keep = s_if.tkeep; e.enc = exp_enc;
        e.plen = s_if.tuser_packet_length; e.inp = s_if.tuser_in_port;
        e.outp = s_if.tuser_out_port; e.inv = s_if.tuser_in_vport;
        e.outv = s_if.tuser_out_vport; e.last = s_if.tlast; e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'hFFFFFFFF, 5'd31, 1'b0};
    tbl[1] = '{32'h0000000F, 5'd3,  1'b0};
    tbl[2] = '{32'h00000001, 5'd0,  1'b0};
    tbl[3] = '{32'h0000FFFF, 5'd15, 1'b0};
    tbl[4] = '{32'h7FFFFFFF, 5'd30, 1'b0};
    tbl[5] = '{32'h000000FF, 5'd7,  1'b0};
    tbl[6] = '{32'h00000005, 5'd2,  1'b1};
    tbl[7] = '{32'h00000000, 5'd0,  1'b1};
    tbl[8] = '{32'h80000000, 5'd31, 1'b1};
    tbl[9] = '{32'h0000F0F0, 5'd15, 1'b1};

    resetn = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    s_if.tkeep = '0;
    s_if.tkeep_enc = '0;
    s_if.tdata = '0;
    s_if.tuser_packet_length = '0;
    s_if.tuser_in_port = '0;
    s_if.tuser_out_port = '0;
    s_if.tuser_in_vport = '0;
    s_if.tuser_out_vport = '0;
    exp_enc = '0;
    cycles(3);
    check("rst_s_tready", 32'(s_if.tready), 32'd0);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_keep_err", 32'(keep_err), 32'd0);
    check("rst_len_err", 32'(len_err_cnt), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("tready_before_rise", 32'(s_if.tready), 32'd0);
    cycles(1);
    check("tready_after_rise", 32'(s_if.tready), 32'd1);

    // Legal keep patterns, each as a single-beat packet.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].keep, tbl[i].enc, 1'b1, 3'(i), 8'h10 + 8'(i), 14'(i + 1));
      check("keep_err_legal", 32'(keep_err), 32'(tbl[i].bad));
    end
    drain();

    // Back-to-back burst: latency 2, no gaps.
    stamp_en = 1;
    for (int i = 0; i < 10; i++) send(32'hFFFFFFFF, 5'd31, 1'(i == 9), 3'd1, 8'h02, 14'd320);
    drain();
    stamp_en = 0;
    check("burst_count", 32'(lat_q.size()), 32'd10);
    for (int i = 0; i < lat_q.size(); i++) check("burst_latency", 32'(lat_q[i]), 32'd2);
    for (int i = 1; i < ocyc_q.size(); i++) check("burst_gap", 32'(ocyc_q[i] - ocyc_q[i-1]), 32'd1);

    // Partial last beat carries its own vports.
    send(32'hFFFFFFFF, 5'd31, 1'b0, 3'd1, 8'h01, 14'd36);
    send(32'h0000000F, 5'd3, 1'b1, 3'd5, 8'h80, 14'd36);
    drain();
    check("last_enc", 32'(last_enc), 32'd3);
    check("last_in_vport", 32'(last_inv), 32'd5);
    check("last_out_vport", 32'(last_outv), 32'h80);

    // Random backpressure over 1000 beats.
    mode = 1;
    for (int i = 0; i < 1000; i++) begin
      int idx;
      idx = $urandom_range(0, 5);
      send(tbl[idx].keep, tbl[idx].enc, 1'(i == 999 || $urandom_range(0, 3) == 0),
           3'($urandom), 8'($urandom), 14'($urandom));
    end
    mode = 0;
    cycles(2);
    drain();

    // Illegal keep: sticky error one cycle after acceptance.
    check("keep_err_pre", 32'(keep_err), 32'd0);
    send(tbl[6].keep, tbl[6].enc, 1'b1, 3'd2, 8'h33, 14'd2);
    check("keep_err_set", 32'(keep_err), 32'd1);
    cycles(5);
    check("keep_err_sticky", 32'(keep_err), 32'd1);
    for (int i = 7; i < 10; i++) begin
      send(tbl[i].keep, tbl[i].enc, 1'b1, 3'(i), 8'(i), 14'd8);
      check("keep_err_illegal", 32'(keep_err), 32'(tbl[i].bad));
    end
    drain();

    // Reset in the middle of a packet with both skid registers occupied.
    mode = 2;
    cycles(2);
    send(32'h00000005, 5'd2, 1'b0, 3'd1, 8'h01, 14'd100);
    for (int i = 0; i < 3; i++) send(32'hFFFFFFFF, 5'd31, 1'b0, 3'd1, 8'h01, 14'd100);
    check("skid_full_tready", 32'(s_if.tready), 32'd0);
    check("skid_full_m_tvalid", 32'(m_if.tvalid), 32'd1);
    resetn = 1'b0;
    cycles(2);
    check("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("midrst_keep_err", 32'(keep_err), 32'd0);
    check("midrst_s_tready", 32'(s_if.tready), 32'd0);
    check("midrst_len_err", 32'(len_err_cnt), 32'd0);
    exp_q.delete();
    mode = 0;
    resetn = 1'b1;
    cycles(2);

    // Length check from IDLE after reset.
    send(32'hFFFFFFFF, 5'd31, 1'b0, 3'd3, 8'h04, 14'd64);
    send(32'hFFFFFFFF, 5'd31, 1'b1, 3'd3, 8'h04, 14'd64);
    cycles(2);
    check("len_ok_64", 32'(len_err_cnt), 32'd0);
    send(32'hFFFFFFFF, 5'd31, 1'b0, 3'd3, 8'h04, 14'd60);
    send(32'hFFFFFFFF, 5'd31, 1'b1, 3'd3, 8'h04, 14'd64);
    cycles(2);
    check("len_bad_60", 32'(len_err_cnt), 32'(LC));
    send(32'h0000000F, 5'd3, 1'b1, 3'd0, 8'h00, 14'd4);
    cycles(2);
    check("len_single_ok", 32'(len_err_cnt), 32'(LC));
    send(32'h0000000F, 5'd3, 1'b1, 3'd0, 8'h00, 14'd5);
    cycles(2);
    check("len_single_bad", 32'(len_err_cnt), 32'(2 * LC));
    check("keep_err_after_rst", 32'(keep_err), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encode_pipe_slice.md
ENCODE_PIPE_SLICE -- requirements
Module: encode_pipe_slice

Interface
REQ-001 C_AXIS_DATA_WIDTH, 256, tdata width in bits; multiple of 8, 64..512 supported.
REQ-002 C_PACKET_LENGTH_WIDTH, 14, width of tuser packet_length field.
REQ-003 C_INPORT_WIDTH, 3, width of in_port and in_vport fields.
REQ-004 C_OUTPORT_WIDTH, 8, width of out_port and out_vport fields.
REQ-005 C_STAGES, 1, number of cascaded register stages, 1..4.
REQ-006 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-007 axi_resetn  in  1  reset, synchronous, active-low.
REQ-008 s_axis_tdata  in  C_AXIS_DATA_WIDTH  input beat data.
REQ-009 s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables, one-hot-per-byte.
REQ-010 s_axis_tuser_packet_length/in_port/out_port/in_vport/out_vport  in  per parameter  sideband, sampled every beat.
REQ-011 s_axis_tvalid / s_axis_tlast  in  1 each  AXI-Stream valid, last beat.
REQ-012 s_axis_tready  out  1  driven directly from a flop, no combinational path from m_axis_tready.
REQ-013 m_axis_tdata  out  C_AXIS_DATA_WIDTH  output beat data.
REQ-014 m_axis_tkeep_enc  out  log2(C_AXIS_DATA_WIDTH/8)  encoded byte count.
REQ-015 m_axis_tuser_packet_length/in_port/out_port/in_vport/out_vport  out  per parameter  each equals the same-named input field of the same beat.
REQ-016 m_axis_tvalid / m_axis_tlast  out  1 each; m_axis_tready  in  1.
REQ-017 keep_err  out  1  sticky: a non-contiguous or all-zero tkeep has been accepted.
REQ-018 len_err_cnt  out  16  saturating count of packets with length mismatch.

Function
REQ-019 Encoding: m_axis_tkeep_enc SHALL equal popcount(tkeep)-1; legal tkeep is LSB-aligned contiguous ones (all-ones -> max value).
REQ-020 Illegal tkeep (zero or holes) SHALL still be forwarded with enc = index of highest set bit (0 for zero) and SHALL set keep_err the cycle after acceptance.
REQ-021 Each stage SHALL be a two-entry skid buffer (main + skid register): full throughput, one beat per cycle with m_axis_tready held high.
REQ-022 Latency SHALL be exactly C_STAGES cycles from input acceptance to m_axis_tvalid, with no bubbles under continuous traffic.
REQ-023 Stage tready SHALL deassert only when its skid register is occupied; skid drains before main accepts new data, preserving order.
REQ-024 m_axis_* SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 Beats SHALL never be dropped, duplicated or reordered; every field travels with its own beat, including in_vport and out_vport.
REQ-026 Packet tracker FSM at input: IDLE -> IN_PKT on accepted non-last beat; IN_PKT -> IDLE on accepted last beat; single-beat packet stays IDLE.
REQ-027 First beat of a packet SHALL latch packet_length; byte sum accumulates popcount(tkeep) in C_PACKET_LENGTH_WIDTH+1 bits.
REQ-028 Simultaneous stall and tlast: check evaluates only on the cycle the tlast beat is accepted (tvalid & tready).

Reset
REQ-029 While axi_resetn=0: all stage valids, s_axis_tready, FSM (IDLE), accumulator, keep_err and len_err_cnt SHALL be 0; data registers are don't-care.
REQ-030 Reset mid-packet SHALL discard all buffered beats; s_axis_tready SHALL rise one cycle after axi_resetn returns high.

Configuration
REQ-031 Macro ENCODE_PIPE_LEN_CHECK_EN defined: REQ-027 active; on accepted tlast, sum != latched length increments len_err_cnt next cycle, saturating at 0xFFFF.
REQ-032 Macro undefined: accumulator and comparison SHALL not be built; len_err_cnt SHALL be constant 0; datapath unchanged.

Structure
REQ-033 Shared package/include SHALL hold log2, popcount-based encode function and the FSM state constants; reused by decoders elsewhere.
REQ-034 One sub-module, encode_skid_stage, parametrised by payload width, SHALL be instantiated C_STAGES times via generate.

Verification
REQ-035 C_STAGES=2, tready=1, 10 back-to-back beats tkeep=0xFFFFFFFF -> outputs at cycles 2..11, enc=31, no gaps.
REQ-036 Last beat tkeep=0x0000000F, in_vport=5, out_vport=0x80 -> enc=3, in_vport=5, out_vport=0x80 on same beat.
REQ-037 m_axis_tready toggled pseudo-randomly 50% over 1000 beats -> output sequence equals input, s_axis_tready never combinationally follows m_axis_tready.
REQ-038 Accepted tkeep=0x00000005 -> keep_err=1 next cycle, stays 1 until reset.
REQ-039 LEN_CHECK_EN, packet_length=64 over 2 beats of 32 bytes -> len_err_cnt 0; packet_length=60 with same beats -> len_err_cnt 1.
REQ-040 Reset asserted mid-packet with skid full -> m_axis_tvalid=0, keep_err=0, next packet checked from IDLE correctly.
